// File: rtl/fp_pack_if.sv
// Operand/result bundle for the fp_pack rounding and packing unit.
// The master drives the operand and the strobe. The slave returns the packed word and the flags.
interface fp_pack_if #(parameter int WID = 32);
    localparam int EMSB = (WID == 64) ? 10 : 7;
    localparam int FMSB = (WID == 64) ? 51 : 22;

    logic            ld;
    logic            sgn;
    logic [EMSB+1:0] exp;
    logic [FMSB+4:0] fract;
    logic [2:0]      rm;
    logic            nan_in;
    logic            inf_in;
    logic [WID-1:0]  o;
    logic            done;
    logic            busy;
    logic            inexact;
    logic            overflow;
    logic            underflow;

    modport master (
        output ld, sgn, exp, fract, rm, nan_in, inf_in,
        input  o, done, busy, inexact, overflow, underflow
    );

    modport slave (
        input  ld, sgn, exp, fract, rm, nan_in, inf_in,
        output o, done, busy, inexact, overflow, underflow
    );
endinterface

// File: rtl/fp_pack.sv
// Normalizes, rounds and packs a sign/exponent/extended-fraction triple into an IEEE word.
// Left normalization moves one bit per cycle. Rounding and packing take one cycle.
module fp_pack #(
    parameter int WID = 32
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ce,
    fp_pack_if.slave  bus
);
    // state | meaning
    // IDLE  | waiting for ld
    // NORM  | normalizing (right by one, or left by one bit per cycle)
    // ROUND | rounding, overflow handling, packing
    // DONE  | result valid, done pulse
    localparam int EMSB = (WID == 64) ? 10 : 7;
    localparam int FMSB = (WID == 64) ? 51 : 22;
    localparam int FW   = FMSB + 5;
    localparam int EW   = EMSB + 3;
    localparam logic [EW-1:0] EMAX = EW'((1 << (EMSB + 1)) - 1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          state, state_n;
    logic            sgn_r, nan_r, inf_r;
    logic [2:0]      rm_r;
    logic [EW-1:0]   exp_r, exp_n, e_rnd;
    logic [FW-1:0]   fr, fr_n;
    logic            load, upd;
    logic            g, s, lsb, inc, ovf, to_inf;
    logic [FMSB+2:0] sum;
    logic [FMSB:0]   man;
    logic [WID-1:0]  o_n;
    logic            inx_n, ovf_n, unf_n;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (ce)
            state <= state_n;
    end

    always_comb begin
        g   = fr[1];
        s   = fr[0];
        lsb = fr[2];
        case (rm_r)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sgn_r & (g | s);
            3'd3:    inc = ~sgn_r & (g | s);
            3'd4:    inc = g;
            default: inc = g & (s | lsb);
        endcase
        sum = {1'b0, fr[FMSB+3:2]} + {{(FMSB+2){1'b0}}, inc};
        man = sum[FMSB:0];
        // A denormal that rounds into the hidden bit keeps exp_r, which is already 1
        if (sum[FMSB+2]) begin
            e_rnd = exp_r + EW'(1);
            man   = '0;
        end else if (sum[FMSB+1]) begin
            e_rnd = exp_r;
        end else begin
            e_rnd = '0;
        end
        ovf    = (e_rnd >= EMAX);
        to_inf = !((rm_r == 3'd1) || (rm_r == 3'd2 && !sgn_r) || (rm_r == 3'd3 && sgn_r));

        if (nan_r) begin
            o_n   = {sgn_r, {(EMSB+1){1'b1}}, 1'b1, {FMSB{1'b0}}};
            inx_n = 1'b0;
            ovf_n = 1'b0;
            unf_n = 1'b0;
        end else if (inf_r) begin
            o_n   = {sgn_r, {(EMSB+1){1'b1}}, {(FMSB+1){1'b0}}};
            inx_n = 1'b0;
            ovf_n = 1'b0;
            unf_n = 1'b0;
        end else begin
            if (ovf)
                o_n = to_inf ? {sgn_r, {(EMSB+1){1'b1}}, {(FMSB+1){1'b0}}}
                             : {sgn_r, {EMSB{1'b1}}, 1'b0, {(FMSB+1){1'b1}}};
            else
                o_n = {sgn_r, e_rnd[EMSB:0], man};
            inx_n = g | s | ovf;
            ovf_n = ovf;
            unf_n = (e_rnd == '0) & (g | s);
        end
    end

    always_comb begin
        state_n = state;
        exp_n   = exp_r;
        fr_n    = fr;
        load    = 1'b0;
        upd     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ld) begin
                    load    = 1'b1;
                    exp_n   = (bus.exp == '0) ? EW'(1) : EW'(bus.exp);
                    fr_n    = bus.fract;
                    state_n = NORM;
                end
            end
            NORM: begin
                if (nan_r || inf_r || fr == '0) begin
                    state_n = ROUND;
                end else if (fr[FMSB+4]) begin
                    fr_n    = {1'b0, fr[FW-1:2], fr[1] | fr[0]};
                    exp_n   = exp_r + EW'(1);
                    state_n = ROUND;
                end else if (!fr[FMSB+3] && exp_r > EW'(1)) begin
                    fr_n  = {fr[FW-2:0], 1'b0};
                    exp_n = exp_r - EW'(1);
                end else begin
                    state_n = ROUND;
                end
            end
            ROUND: begin
                upd     = 1'b1;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o         <= '0;
            bus.done      <= 1'b0;
            bus.inexact   <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            sgn_r         <= 1'b0;
            nan_r         <= 1'b0;
            inf_r         <= 1'b0;
            rm_r          <= '0;
            exp_r         <= '0;
            fr            <= '0;
        end else if (ce) begin
            exp_r    <= exp_n;
            fr       <= fr_n;
            bus.done <= (state == ROUND);
            if (load) begin
                sgn_r <= bus.sgn;
                nan_r <= bus.nan_in;
                inf_r <= bus.inf_in;
                rm_r  <= bus.rm;
            end
            if (upd) begin
                bus.o         <= o_n;
                bus.inexact   <= inx_n;
                bus.overflow  <= ovf_n;
                bus.underflow <= unf_n;
            end
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_fp_pack.sv
// Scoreboarded bench for fp_pack at WID=32: rounding modes, special values,
// latency, reset, clock-enable gating and strobe handling.
module tb_fp_pack;
    logic clk = 1'b0;
    logic rst;
    logic ce;

    always #5 clk = ~clk;

    fp_pack_if #(.WID(32)) bus();

    fp_pack #(.WID(32)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    typedef struct {
        logic        s;
        logic [8:0]  e;
        logic [26:0] f;
        logic [2:0]  rm;
        logic        nan;
        logic        inf;
        logic [31:0] o;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] o;
        logic [2:0]  fl;
        int          lat;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sbq[$];

    function automatic vec_t mk(input logic s, input logic [8:0] e, input logic [26:0] f,
                                input logic [2:0] rm, input logic nan, input logic inf,
                                input logic [31:0] o, input logic [2:0] fl, input int lat);
        vec_t v;
        v.s = s; v.e = e; v.f = f; v.rm = rm; v.nan = nan; v.inf = inf;
        v.o = o; v.fl = fl; v.lat = lat;
        return v;
    endfunction

    // Expected flags are packed {inexact, overflow, underflow}
    task automatic drive_op(input vec_t v);
        exp_t x;
        x.o = v.o; x.fl = v.fl; x.lat = v.lat;
        sbq.push_back(x);
        bus.sgn = v.s; bus.exp = v.e; bus.fract = v.f; bus.rm = v.rm;
        bus.nan_in = v.nan; bus.inf_in = v.inf;
        bus.ld = 1'b1;
        @(negedge clk);
        bus.ld = 1'b0;
    endtask

    task automatic wait_done(input int start, input int limit, output int cyc);
        cyc = start;
        while (bus.done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        ce = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o !== 32'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0 ||
            {bus.inexact, bus.overflow, bus.underflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset: o=%h done=%b busy=%b flags=%b, want all zero",
                     bus.o, bus.done, bus.busy, {bus.inexact, bus.overflow, bus.underflow});
        end
        rst = 1'b0;
        ce = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        int cyc;
        exp_t x;
        foreach (vecs[i]) begin
            drive_op(vecs[i]);
            wait_done(1, 60, cyc);
            x = sbq.pop_front();
            checks++;
            if (cyc !== x.lat) begin
                errors++;
                $display("FAIL vec%0d latency: got %0d want %0d", i, cyc, x.lat);
            end
            checks++;
            if (bus.o !== x.o) begin
                errors++;
                $display("FAIL vec%0d o: got %h want %h", i, bus.o, x.o);
            end
            checks++;
            if ({bus.inexact, bus.overflow, bus.underflow} !== x.fl) begin
                errors++;
                $display("FAIL vec%0d flags: got %b want %b", i,
                         {bus.inexact, bus.overflow, bus.underflow}, x.fl);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d pulse: done=%b busy=%b want 0 0", i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_ld_busy();
        int cyc;
        int extra;
        exp_t x;
        drive_op(mk(0, 9'h07F, 27'h0000004, 0, 0, 0, 32'h34000000, 3'b000, 26));
        repeat (4) @(negedge clk);
        bus.sgn = 1'b1; bus.exp = 9'h0FF; bus.fract = 27'h4000003; bus.rm = 3'd3;
        bus.ld = 1'b1;
        @(negedge clk);
        bus.ld = 1'b0;
        wait_done(6, 60, cyc);
        x = sbq.pop_front();
        checks++;
        if (cyc !== x.lat || bus.o !== x.o) begin
            errors++;
            $display("FAIL ld_busy: cycle %0d o=%h, want cycle %0d o=%h", cyc, bus.o, x.lat, x.o);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ld_busy_extra: got %0d extra done cycles want 0", extra);
        end
    endtask

    task automatic test_ce_gating();
        int cyc;
        exp_t x;
        drive_op(mk(0, 9'h07F, 27'h0000004, 0, 0, 0, 32'h34000000, 3'b000, 31));
        repeat (4) @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ce_hold: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        ce = 1'b1;
        wait_done(10, 80, cyc);
        x = sbq.pop_front();
        checks++;
        if (cyc !== x.lat) begin
            errors++;
            $display("FAIL ce_latency: got %0d want %0d", cyc, x.lat);
        end
        checks++;
        if (bus.o !== x.o) begin
            errors++;
            $display("FAIL ce_o: got %h want %h", bus.o, x.o);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int dones;
        exp_t x;
        drive_op(mk(0, 9'h07F, 27'h0000004, 0, 0, 0, 32'h34000000, 3'b000, 26));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        x = sbq.pop_front();
        checks++;
        if (bus.o !== 32'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0 ||
            {bus.inexact, bus.overflow, bus.underflow} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid: o=%h done=%b busy=%b flags=%b, want all zero (abandoned o=%h)",
                     bus.o, bus.done, bus.busy, {bus.inexact, bus.overflow, bus.underflow}, x.o);
        end
        rst = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL rst_mid_done: got %0d done cycles want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        exp_t x;
        drive_op(mk(0, 9'h07F, 27'h2000000, 0, 0, 0, 32'h3F800000, 3'b000, 3));
        wait_done(1, 60, cyc);
        x = sbq.pop_front();
        checks++;
        if (cyc !== x.lat || bus.o !== x.o) begin
            errors++;
            $display("FAIL b2b_first: cycle %0d o=%h, want cycle %0d o=%h", cyc, bus.o, x.lat, x.o);
        end
        x.o = 32'h40000000; x.fl = 3'b000; x.lat = 3;
        sbq.push_back(x);
        bus.sgn = 1'b0; bus.exp = 9'h07F; bus.fract = 27'h4000000; bus.rm = 3'd0;
        bus.nan_in = 1'b0; bus.inf_in = 1'b0;
        bus.ld = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ld: busy=%b want 0", bus.busy);
        end
        @(negedge clk);
        bus.ld = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_ld: busy=%b want 1", bus.busy);
        end
        wait_done(1, 60, cyc);
        x = sbq.pop_front();
        checks++;
        if (cyc !== x.lat || bus.o !== x.o) begin
            errors++;
            $display("FAIL b2b_second: cycle %0d o=%h, want cycle %0d o=%h", cyc, bus.o, x.lat, x.o);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.ld = 1'b0; bus.sgn = 1'b0; bus.exp = '0; bus.fract = '0; bus.rm = '0;
        bus.nan_in = 1'b0; bus.inf_in = 1'b0;
        rst = 1'b1;
        ce = 1'b0;

        vecs.push_back(mk(0, 9'h07F, 27'h2000000, 0, 0, 0, 32'h3F800000, 3'b000, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h4000000, 0, 0, 0, 32'h40000000, 3'b000, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h0000004, 0, 0, 0, 32'h34000000, 3'b000, 26));
        vecs.push_back(mk(0, 9'h07F, 27'h2000002, 0, 0, 0, 32'h3F800000, 3'b100, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000002, 3, 0, 0, 32'h3F800001, 3'b100, 3));
        vecs.push_back(mk(0, 9'h0FF, 27'h2000000, 0, 0, 0, 32'h7F800000, 3'b110, 3));
        vecs.push_back(mk(0, 9'h0FF, 27'h2000000, 1, 0, 0, 32'h7F7FFFFF, 3'b110, 3));
        vecs.push_back(mk(0, 9'h001, 27'h1000000, 0, 0, 0, 32'h00400000, 3'b000, 3));
        vecs.push_back(mk(0, 9'h001, 27'h1000001, 0, 0, 0, 32'h00400000, 3'b101, 3));
        vecs.push_back(mk(1, 9'h07F, 27'h2000000, 0, 1, 0, 32'hFFC00000, 3'b000, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000000, 0, 0, 1, 32'h7F800000, 3'b000, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000000, 0, 1, 1, 32'h7FC00000, 3'b000, 3));
        vecs.push_back(mk(1, 9'h07F, 27'h0000000, 0, 0, 0, 32'h80000000, 3'b000, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000002, 4, 0, 0, 32'h3F800001, 3'b100, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000006, 0, 0, 0, 32'h3F800002, 3'b100, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000006, 1, 0, 0, 32'h3F800001, 3'b100, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000002, 7, 0, 0, 32'h3F800000, 3'b100, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000006, 5, 0, 0, 32'h3F800002, 3'b100, 3));
        vecs.push_back(mk(1, 9'h07F, 27'h2000001, 2, 0, 0, 32'hBF800001, 3'b100, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h2000001, 2, 0, 0, 32'h3F800000, 3'b100, 3));
        vecs.push_back(mk(0, 9'h07F, 27'h3FFFFFE, 0, 0, 0, 32'h40000000, 3'b100, 3));
        vecs.push_back(mk(0, 9'h0FE, 27'h3FFFFFE, 0, 0, 0, 32'h7F800000, 3'b110, 3));
        vecs.push_back(mk(0, 9'h0FF, 27'h2000000, 2, 0, 0, 32'h7F7FFFFF, 3'b110, 3));
        vecs.push_back(mk(1, 9'h0FF, 27'h2000000, 2, 0, 0, 32'hFF800000, 3'b110, 3));
        vecs.push_back(mk(1, 9'h0FF, 27'h2000000, 3, 0, 0, 32'hFF7FFFFF, 3'b110, 3));
        vecs.push_back(mk(0, 9'h001, 27'h1FFFFFE, 0, 0, 0, 32'h00800000, 3'b100, 3));
        vecs.push_back(mk(0, 9'h000, 27'h1000000, 0, 0, 0, 32'h00400000, 3'b000, 3));
        vecs.push_back(mk(0, 9'h003, 27'h0400000, 0, 0, 0, 32'h00400000, 3'b000, 5));
        vecs.push_back(mk(0, 9'h07F, 27'h4000006, 0, 0, 0, 32'h40000001, 3'b100, 3));
        vecs.push_back(mk(0, 9'h0FE, 27'h4000000, 0, 0, 0, 32'h7F800000, 3'b110, 3));

        test_reset();
        test_vectors();
        test_ld_busy();
        test_ce_gating();
        test_rst_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
